// File: rtl/mips_pkg.sv
// Shared MIPS definitions: funct codes used by the HI/LO unit and its sequencer states.
// No logic, no latency.
// No flow control.
package mips_pkg;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } hilo_state_t;

  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction

endpackage

// File: rtl/hilo_sign_adjust.sv
// Conditional two's-complement negate of a W-bit value.
// Combinational, zero latency.
// No flow control.
module hilo_sign_adjust #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register file with iterative mult/multu/div/divu and single-cycle mthi/mtlo.
// Mul/div: accept edge plus XLEN iterations plus one fixup edge; mthi/mtlo write on the accept edge.
// stall holds the issuing instruction until done; requests arriving while busy are ignored.
module hilo_muldiv_unit
  import mips_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            we_hilo,
  input  logic [5:0]      funct,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            stall,
  output logic            done
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  hilo_state_t       state;
  logic [CNT_W-1:0]  counter;
  logic [XLEN-1:0]   op_b;
  logic [2*XLEN-1:0] acc;
  logic              res_sign;
  logic              rem_sign;
  logic              div_zero;
  logic              div_op;

  logic              is_div;
  logic              rs_neg;
  logic              rt_neg;
  logic              accept_muldiv;
  logic [XLEN-1:0]   abs_rs;
  logic [XLEN-1:0]   abs_rt;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;

  assign is_div = (funct == FN_DIV) || (funct == FN_DIVU);
  assign rs_neg = ((funct == FN_MULT) || (funct == FN_DIV)) && rs_data[XLEN-1];
  assign rt_neg = ((funct == FN_MULT) || (funct == FN_DIV)) && rt_data[XLEN-1];

  // The done cycle still presents the retiring instruction; it must not re-issue.
  assign accept_muldiv = (state == IDLE) && we_hilo && is_muldiv(funct) && !done;
  assign stall         = busy || accept_muldiv;

  hilo_sign_adjust #(.W(XLEN)) u_abs_rs (.value(rs_data), .negate(rs_neg), .result(abs_rs));
  hilo_sign_adjust #(.W(XLEN)) u_abs_rt (.value(rt_data), .negate(rt_neg), .result(abs_rt));

  // Shift-add: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, op_b} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // Restoring divide: acc = {partial remainder, dividend/quotient bits}.
  assign div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, op_b};
  assign div_next  = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  hilo_sign_adjust #(.W(2*XLEN)) u_fix_prod (.value(acc), .negate(res_sign), .result(prod_fix));
  hilo_sign_adjust #(.W(XLEN)) u_fix_quot (.value(acc[XLEN-1:0]), .negate(res_sign), .result(quot_fix));
  hilo_sign_adjust #(.W(XLEN)) u_fix_rem (.value(acc[2*XLEN-1:XLEN]), .negate(rem_sign), .result(rem_fix));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      counter  <= '0;
      op_b     <= '0;
      acc      <= '0;
      res_sign <= 1'b0;
      rem_sign <= 1'b0;
      div_zero <= 1'b0;
      div_op   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_muldiv) begin
            op_b     <= is_div ? abs_rt : abs_rs;
            acc      <= {{XLEN{1'b0}}, (is_div ? abs_rs : abs_rt)};
            res_sign <= rs_neg ^ rt_neg;
            rem_sign <= rs_neg;
            div_zero <= (rt_data == '0);
            div_op   <= is_div;
            counter  <= '0;
            busy     <= 1'b1;
            state    <= is_div ? DIV : MUL;
          end else if (we_hilo && (funct == FN_MTHI)) begin
            hi <= rs_data;
          end else if (we_hilo && (funct == FN_MTLO)) begin
            lo <= rs_data;
          end
        end
        MUL, DIV: begin
          acc     <= (state == MUL) ? mul_next : div_next;
          counter <= counter + CNT_W'(1);
          if (counter == LAST_ITER) state <= FIX;
        end
        FIX: begin
          if (div_op) begin
            // Divide by zero leaves rem = |rs|, so rem_fix already equals rs_data.
            lo <= div_zero ? '1 : quot_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit.
module tb_hilo_muldiv_unit;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        we_hilo;
  logic [5:0]  funct;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;

  int          tests = 0;
  int          failed = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  always #5 clock = ~clock;

  hilo_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clock(clock), .reset_n(reset_n), .we_hilo(we_hilo), .funct(funct),
    .rs_data(rs_data), .rt_data(rt_data), .hi(hi), .lo(lo),
    .busy(busy), .stall(stall), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue a mul/div, hold the instruction until done, then verify timing and results.
  task automatic do_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] want_hi, input logic [31:0] want_lo);
    int n;
    int busy_cnt;
    int bad;
    bit got;
    n = 0; busy_cnt = 0; bad = 0; got = 0;
    we_hilo = 1'b1; funct = f; rs_data = a; rt_data = b;
    #1;
    check({tag, " stall_req"}, 64'(stall), 64'd1);
    while (!got && n < 100) begin
      tick();
      n++;
      if (done) got = 1;
      else begin
        if (busy) busy_cnt++;
        if (!stall || hi !== exp_hi || lo !== exp_lo) bad++;
      end
    end
    check({tag, " latency"}, 64'(n), 64'd34);
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, " hold_viol"}, 64'(bad), 64'd0);
    check({tag, " stall_done"}, 64'(stall), 64'd0);
    check({tag, " busy_done"}, 64'(busy), 64'd0);
    check({tag, " hi"}, 64'(hi), 64'(want_hi));
    check({tag, " lo"}, 64'(lo), 64'(want_lo));
    exp_hi = want_hi;
    exp_lo = want_lo;
    we_hilo = 1'b0;
    tick();
    check({tag, " done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int pulses;
    logic [31:0] got_hi;
    logic [31:0] got_lo;

    reset_n = 1'b0; we_hilo = 1'b0; funct = '0; rs_data = '0; rt_data = '0;
    exp_hi = '0; exp_lo = '0;
    repeat (3) tick();
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst stall", 64'(stall), 64'd0);
    reset_n = 1'b1;
    tick();

    // MTHI then MTLO on consecutive cycles
    we_hilo = 1'b1; funct = FN_MTHI; rs_data = 32'h1234_5678;
    #1 check("mthi stall", 64'(stall), 64'd0);
    tick();
    check("mthi hi", 64'(hi), 64'h1234_5678);
    check("mthi lo", 64'(lo), 64'd0);
    funct = FN_MTLO; rs_data = 32'h9ABC_DEF0;
    #1 check("mtlo stall", 64'(stall), 64'd0);
    tick();
    check("mtlo lo", 64'(lo), 64'h9ABC_DEF0);
    check("mtlo hi", 64'(hi), 64'h1234_5678);
    check("mtx busy", 64'(busy), 64'd0);
    check("mtx done", 64'(done), 64'd0);
    exp_hi = 32'h1234_5678; exp_lo = 32'h9ABC_DEF0;

    // Unrelated funct (jr) with the strobe set
    funct = 6'h08; rs_data = 32'hDEAD_BEEF;
    #1 check("jr stall", 64'(stall), 64'd0);
    tick();
    check("jr hi", 64'(hi), 64'(exp_hi));
    check("jr lo", 64'(lo), 64'(exp_lo));
    check("jr busy", 64'(busy), 64'd0);
    we_hilo = 1'b0;
    tick();

    do_op("multu_max", FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op("mult_neg", FN_MULT, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_op("div_neg", FN_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("divu_zero", FN_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    do_op("div_ovf", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // MULT request while DIVU 1000/7 is in flight must be ignored
    we_hilo = 1'b1; funct = FN_DIVU; rs_data = 32'd1000; rt_data = 32'd7;
    tick();
    check("intf busy", 64'(busy), 64'd1);
    repeat (4) tick();
    funct = FN_MULT; rs_data = 32'hFFFF_FFF9; rt_data = 32'd3;
    repeat (3) tick();
    we_hilo = 1'b0;
    pulses = 0; got_hi = '0; got_lo = '0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done) begin
        pulses++;
        got_hi = hi;
        got_lo = lo;
      end
    end
    check("intf pulses", 64'(pulses), 64'd1);
    check("intf hi", 64'(got_hi), 64'd6);
    check("intf lo", 64'(got_lo), 64'h8E);
    check("intf busy_end", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a DIV
    we_hilo = 1'b1; funct = FN_DIV; rs_data = 32'd1000; rt_data = 32'd7;
    tick();
    we_hilo = 1'b0;
    repeat (10) tick();
    check("middiv busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrst hi", 64'(hi), 64'd0);
    check("midrst lo", 64'(lo), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    exp_hi = '0; exp_lo = '0;
    tick();
    reset_n = 1'b1;
    tick();
    do_op("multu_post", FN_MULTU, 32'd12345, 32'd1000, 32'h0000_0000, 32'h00BC_5EA8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
